bcd_to_bin_seq: RTL
===================

// Module: bcd_to_bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter; the inverse of the double_dabble binary-to-BCD path.
//  Uses reverse double dabble: shift right, then per-digit "subtract 3 if >= 8".
//  Converts a digit-entered guess or preset value into the 8-bit game domain.
//  Sits between the debounced input logic and higher_or_lower_fsm; start/busy/done handshake.
// PARAMETERS
//  DIGITS   3    number of packed BCD digits on bcd_in
//  BIN_W    10   binary result width; must satisfy 2**BIN_W > 10**DIGITS-1 (sim assertion)
//  MAX_VAL  255  range limit; results above it raise over_max
// PORTS
//  clk       in   1          system clock (100 MHz)
//  reset     in   1          synchronous, active-high reset
//  start     in   1          request conversion; sampled only in IDLE
//  bcd_in    in   4*DIGITS   packed BCD, digit 0 in [3:0]; latched on accepted start
//  busy      out  1          high from the cycle after accept until done
//  done      out  1          single-cycle pulse; bin_out and flags are valid and held
//  bin_out   out  BIN_W      converted value; holds until the next done
//  invalid   out  1          latched input had a digit > 9; held with bin_out
//  over_max  out  1          bin_out > MAX_VAL; held with bin_out
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, invalid, over_max = 0; bin_out = 0; internal regs cleared.
//  States: IDLE, SHIFT, FINISH.
//   IDLE -> SHIFT: start=1 and all latched digits <= 9.
//     On accept: load bcd_reg = bcd_in, bin_reg = 0, cnt = 0.
//   IDLE -> FINISH: start=1 and any digit > 9. Set invalid=1, bin_out=0, over_max=0.
//   SHIFT: each cycle, shift {bcd_reg, bin_reg} right by 1.
//     Then any digit of the shifted bcd_reg >= 8 loses 3; the adjusted value is registered.
//     cnt++. Exit to FINISH after exactly BIN_W SHIFT cycles.
//   FINISH: one cycle. done=1; bin_out <= bin_reg (valid path); invalid=0 on the valid path.
//     over_max <= (bin_reg > MAX_VAL). Next state IDLE.
//  Latency, start edge N to done:
//   valid input: done high in cycle N+BIN_W+1.
//   invalid input: done high in cycle N+1.
//  busy=1 in SHIFT and FINISH; done=1 only in FINISH; busy=0 in IDLE.
//  start in SHIFT/FINISH is ignored (no queuing). Start in the cycle after done is accepted.
//  bcd_in changes after accept have no effect (latched copy used).
//  Reset mid-conversion: next cycle IDLE, all outputs at reset values, no done pulse.
//  Arithmetic: digit adjust is 4-bit, result cannot underflow (applied only to >= 8).
//   bin_reg is BIN_W bits; the compare against MAX_VAL is unsigned, at BIN_W width.
//  Round-trip: bin_out == value whose double_dabble BCD equals bcd_in, for all valid inputs.
// STRUCTURE
//  Shared package (hol_pkg): state encoding localparams (IDLE/SHIFT/FINISH).
//   Also BCD_DIGIT_W=4 and the game range constant MAX_VAL=255.
//  Sub-module bcd_digit_adjust: combinational 4-bit "if (d>=8) d-3".
//   Instantiated DIGITS times via generate.
//  Counter width: $clog2(BIN_W+1).
// TESTING
//  start bcd_in=12'h000 -> done at N+11, bin_out=0, invalid=0, over_max=0.
//  start 12'h255 -> bin_out=255, over_max=0; then start 12'h256 -> bin_out=256, over_max=1.
//  start 12'h999 -> bin_out=10'h3E7, over_max=1; busy high for exactly 11 cycles.
//  start 12'h1A3 -> done at N+1, invalid=1, bin_out=0; next start 12'h042 -> bin_out=42, invalid=0.
//  start held high for 20 cycles with bcd_in=12'h123 -> one done at N+11, then re-accept at N+12.
//   bcd_in toggled mid-run is ignored.
//  start 12'h777, reset=1 at N+5 -> busy=0 at N+6, no done pulse, bin_out=0.
//  Exhaustive sweep 0..999 -> bin_out matches decimal value each time.

Source files
------------

// File: rtl/hol_pkg.sv
// Shared constants for the higher-or-lower game datapath: FSM state codes,
// BCD digit width and the game's numeric range limit.
package hol_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int MAX_VAL     = 255;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SHIFT  = 2'd1;
  localparam state_t FINISH = 2'd2;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step of reverse double dabble: a digit that
// reached 8 or more after the right shift gives back 3.
module bcd_digit_adjust
  import hol_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_in,
  output logic [BCD_DIGIT_W-1:0] d_out
);

  // subtract 3 only from digits >= 8, so the 4-bit result never wraps
  always_comb begin
    d_out = d_in;
    if (d_in >= BCD_DIGIT_W'(8)) d_out = d_in - BCD_DIGIT_W'(3);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one result bit
// per SHIFT cycle, with start/busy/done handshake and invalid/over_max flags.
module bcd_to_bin_seq
  import hol_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int BIN_W   = 10,
  parameter int MAX_VAL = hol_pkg::MAX_VAL
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          invalid,
  output logic                          over_max
);

  localparam int                BCD_W    = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0]  MAX_BIN  = BIN_W'(MAX_VAL);

  // the binary register must hold the largest DIGITS-digit decimal value
  if ((2 ** BIN_W) <= ((10 ** DIGITS) - 1)) begin : g_range_chk
    $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
  end

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               invalid_q, invalid_d;
  logic               over_max_q, over_max_d;

  logic [BCD_W-1:0]   bcd_shr, bcd_adj;
  logic [BIN_W-1:0]   bin_shr;
  logic               in_bad;

  // one joint right shift of {bcd, bin}; the bcd LSB falls into the bin MSB
  assign bcd_shr = bcd_q >> 1;
  assign bin_shr = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_in  (bcd_shr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // flag any non-decimal digit on the incoming word
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(9)) in_bad = 1'b1;
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      bin_out_q  <= '0;
      invalid_q  <= 1'b0;
      over_max_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      bin_out_q  <= bin_out_d;
      invalid_q  <= invalid_d;
      over_max_q <= over_max_d;
    end
  end

  // next-state: bad digits skip straight to FINISH, otherwise BIN_W shifts
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = in_bad ? FINISH : SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath; results are loaded on entry to FINISH so they are valid with done
  always_comb begin
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    bin_out_d  = bin_out_q;
    invalid_d  = invalid_q;
    over_max_d = over_max_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d = bcd_in;
          bin_d = '0;
          cnt_d = '0;
          if (in_bad) begin
            invalid_d  = 1'b1;
            bin_out_d  = '0;
            over_max_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_shr;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bin_out_d  = bin_shr;
          invalid_d  = 1'b0;
          over_max_d = (bin_shr > MAX_BIN);
        end
      end
      default: ;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == FINISH);
    bin_out  = bin_out_q;
    invalid  = invalid_q;
    over_max = over_max_q;
  end

endmodule
